// File: rtl/feynman_vector_driver_if.sv
// Handshake and gate-side bundle for the Feynman gate vector driver.
// master = sequencer side, slave = controller/gate side.
interface feynman_vector_driver_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             dut_a;
  logic             dut_b;
  logic             dut_o1;
  logic             dut_o2;
  logic             busy;
  logic             done;
  logic             pass_flag;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] tog_cnt;

  modport master (
    input  start, dut_o1, dut_o2,
    output dut_a, dut_b, busy, done,
    output pass_flag, err_cnt, tog_cnt
  );

  modport slave (
    output start, dut_o1, dut_o2,
    input  dut_a, dut_b, busy, done,
    input  pass_flag, err_cnt, tog_cnt
  );
endinterface

// File: rtl/feynman_vector_driver.sv
// Self-timed exhaustive stimulus/checker for a CNOT gate.
// Ports: clk, rst (sync high), bus (master: start in, a/b out, o1/o2 in, status out).
module feynman_vector_driver #(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_PASSES  = 1,
  parameter int CNT_W       = 16
) (
  input logic                     clk,
  input logic                     rst,
  feynman_vector_driver_if.master bus
);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [HW-1:0]    r_hold;
  logic [PW-1:0]    r_pass;
  logic [1:0]       r_vec;
  logic             r_first;
  logic             r_o1_q;
  logic             r_o2_q;
  logic             r_pass_flag;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_tog;

  logic             w_sample;
  logic             w_last;
  logic             w_mis;
  logic [1:0]       w_tog_inc;
  logic [CNT_W:0]   w_tog_sum;

  // Vector index bit0 is a, bit1 is b: 0->(0,0) 1->(1,0) 2->(0,1) 3->(1,1).
  // After vector 3 the index wraps to 0, so DONE/IDLE drive (0,0).
  assign bus.dut_a     = r_vec[0];
  assign bus.dut_b     = r_vec[1];
  assign bus.pass_flag = r_pass_flag;
  assign bus.err_cnt   = r_err;
  assign bus.tog_cnt   = r_tog;

  assign w_sample = (r_state == S_RUN) &&
                    (r_hold == HW'(HOLD_CYCLES - 1));
  assign w_last   = w_sample && (r_vec == 2'd3) &&
                    (r_pass == PW'(NUM_PASSES - 1));
  assign w_mis    = (bus.dut_o1 != r_vec[0]) ||
                    (bus.dut_o2 != (r_vec[0] ^ r_vec[1]));

  assign w_tog_inc = {1'b0, bus.dut_o1 ^ r_o1_q} +
                     {1'b0, bus.dut_o2 ^ r_o2_q};
  assign w_tog_sum = {1'b0, r_tog} + {{(CNT_W-1){1'b0}}, w_tog_inc};

  always_comb begin
    w_next   = r_state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_RUN;
      S_RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_pass      <= '0;
      r_vec       <= '0;
      r_first     <= 1'b0;
      r_o1_q      <= 1'b0;
      r_o2_q      <= 1'b0;
      r_pass_flag <= 1'b0;
      r_err       <= '0;
      r_tog       <= '0;
    end else begin
      r_state <= w_next;
      r_o1_q  <= bus.dut_o1;
      r_o2_q  <= bus.dut_o2;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_err       <= '0;
            r_tog       <= '0;
            r_pass_flag <= 1'b0;
            r_vec       <= '0;
            r_hold      <= '0;
            r_pass      <= '0;
            r_first     <= 1'b1;
          end
        end
        S_RUN: begin
          r_first <= 1'b0;
          // o1_q/o2_q still hold pre-run values on the first cycle
          if (!r_first) begin
            if (w_tog_sum[CNT_W]) r_tog <= '1;
            else r_tog <= w_tog_sum[CNT_W-1:0];
          end
          if (w_sample) begin
            r_hold <= '0;
            r_vec  <= r_vec + 2'd1;
            if (w_mis && (r_err != '1)) r_err <= r_err + 1'b1;
            if (r_vec == 2'd3) r_pass <= r_pass + 1'b1;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_DONE: r_pass_flag <= (r_err == '0);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_feynman_vector_driver.sv
// Directed bench for feynman_vector_driver.
// Three instances cover PASSES=1, PASSES=2 and CNT_W=2 saturation.
module tb_feynman_vector_driver;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] stuck;
  always #5 clk = ~clk;

  feynman_vector_driver_if #(.CNT_W(16)) if0 ();
  feynman_vector_driver_if #(.CNT_W(16)) if1 ();
  feynman_vector_driver_if #(.CNT_W(2))  if2 ();

  // Gate model: o1=a, o2=a^b, optional o2 stuck-at-0
  assign if0.dut_o1 = if0.dut_a;
  assign if0.dut_o2 = stuck[0] ? 1'b0 : (if0.dut_a ^ if0.dut_b);
  assign if1.dut_o1 = if1.dut_a;
  assign if1.dut_o2 = stuck[1] ? 1'b0 : (if1.dut_a ^ if1.dut_b);
  assign if2.dut_o1 = if2.dut_a;
  assign if2.dut_o2 = stuck[2] ? 1'b0 : (if2.dut_a ^ if2.dut_b);

  feynman_vector_driver #(.HOLD_CYCLES(4), .NUM_PASSES(1), .CNT_W(16))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  feynman_vector_driver #(.HOLD_CYCLES(4), .NUM_PASSES(2), .CNT_W(16))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  feynman_vector_driver #(.HOLD_CYCLES(4), .NUM_PASSES(2), .CNT_W(2))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  int          sel;
  logic        busy_s, done_s, pf_s, a_s, b_s;
  logic [15:0] err_s, tog_s;

  always_comb begin
    busy_s = if0.busy; done_s = if0.done; pf_s = if0.pass_flag;
    a_s = if0.dut_a; b_s = if0.dut_b;
    err_s = if0.err_cnt; tog_s = if0.tog_cnt;
    case (sel)
      1: begin
        busy_s = if1.busy; done_s = if1.done; pf_s = if1.pass_flag;
        a_s = if1.dut_a; b_s = if1.dut_b;
        err_s = if1.err_cnt; tog_s = if1.tog_cnt;
      end
      2: begin
        busy_s = if2.busy; done_s = if2.done; pf_s = if2.pass_flag;
        a_s = if2.dut_a; b_s = if2.dut_b;
        err_s = {14'd0, if2.err_cnt}; tog_s = {14'd0, if2.tog_cnt};
      end
      default: ;
    endcase
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0: if0.start = v;
      1: if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  task automatic run(input string tag, input int s, input logic stk,
                     input int exp_busy, input int exp_err,
                     input int exp_tog, input int exp_pf,
                     input int restart_at, input bit start_in_done);
    int n;
    int idx;
    bit vec_ok;
    sel = s;
    stuck[s] = stk;
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    n = 0;
    vec_ok = 1'b1;
    while (busy_s && n < 200) begin
      n++;
      if (n == 1)
        chk({tag, "_clear"}, int'(pf_s) + int'(err_s) + int'(tog_s), 0);
      idx = ((n - 1) / 4) % 4;
      if (int'({b_s, a_s}) != idx) vec_ok = 1'b0;
      if (n == restart_at) set_start(s, 1'b1);
      tick();
      if (n == restart_at) set_start(s, 1'b0);
    end
    chk({tag, "_busy_len"}, n, exp_busy);
    chk({tag, "_vec_order"}, int'(vec_ok), 1);
    chk({tag, "_done"}, int'(done_s), 1);
    chk({tag, "_idle_ab"}, int'({a_s, b_s}), 0);
    chk({tag, "_err"}, int'(err_s), exp_err);
    chk({tag, "_tog"}, int'(tog_s), exp_tog);
    if (start_in_done) set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    chk({tag, "_done_pulse"}, int'(done_s), 0);
    chk({tag, "_pass_flag"}, int'(pf_s), exp_pf);
    if (start_in_done) begin
      tick();
      chk({tag, "_start_in_done"}, int'(busy_s), 0);
      chk({tag, "_err_held"}, int'(err_s), exp_err);
    end
  endtask

  typedef struct {
    string tag;
    int    s;
    logic  stk;
    int    busy_n;
    int    err;
    int    tog;
    int    pf;
  } vec_t;

  vec_t tbl[5];
  bit   done_seen;

  initial begin
    tbl[0] = '{"t1", 0, 1'b0, 16, 0, 5, 1};
    tbl[1] = '{"t2", 1, 1'b0, 32, 0, 11, 1};
    tbl[2] = '{"t3", 0, 1'b1, 16, 2, 3, 0};
    tbl[3] = '{"t4", 2, 1'b1, 32, 3, 3, 0};
    tbl[4] = '{"t1b", 0, 1'b0, 16, 0, 5, 1};

    sel = 0;
    stuck = 3'b000;
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", int'(if0.busy), 0);
    chk("rst_done", int'(if0.done), 0);
    chk("rst_pass", int'(if0.pass_flag), 0);
    chk("rst_a", int'(if0.dut_a), 0);
    chk("rst_b", int'(if0.dut_b), 0);
    chk("rst_err", int'(if0.err_cnt), 0);
    chk("rst_tog", int'(if0.tog_cnt), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].tag, tbl[i].s, tbl[i].stk, tbl[i].busy_n,
          tbl[i].err, tbl[i].tog, tbl[i].pf, 0, 1'b0);
      stuck = 3'b000;
      tick();
    end

    // T5: start mid-run and during DONE are ignored
    run("t5", 0, 1'b0, 16, 0, 5, 1, 5, 1'b1);
    tick();

    // T6: reset on RUN cycle 9 abandons the run
    sel = 0;
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    for (int k = 1; k < 9; k++) tick();
    chk("t6_busy_before", int'(busy_s), 1);
    rst = 1'b1;
    tick();
    chk("t6_busy", int'(busy_s), 0);
    chk("t6_ab", int'({a_s, b_s}), 0);
    chk("t6_err", int'(err_s), 0);
    chk("t6_tog", int'(tog_s), 0);
    chk("t6_done", int'(done_s), 0);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done_s || busy_s) done_seen = 1'b1;
    end
    chk("t6_no_done", int'(done_seen), 0);
    run("t6_rerun", 0, 1'b0, 16, 0, 5, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
